// File: rtl/mult_share_pkg.sv
// Shared definitions for the shared-multiplier arbiter: state encoding,
// default datapath sizing and a constant log2 helper.
package mult_share_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEF_W   = 16;
    localparam int DEF_LAT = 2;

    // Ceiling log2, usable in constant expressions (clog2(1) == 0).
    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/mult_share_arb_if.sv
// Request/result bundle between the client blocks and mult_share_arb.
//
// Handshake rules: a transfer on a request lane happens on a rising clock
// edge where req_valid[i] and req_ready[i] are both high. A requester holds
// req_valid[i] and its operand slices steady until that edge. On the result
// side a transfer happens on an edge where res_valid and res_ready are both
// high. res_valid, res_id and res_p stay steady until then, and res_ready
// seen while res_valid is low has no effect.
interface mult_share_arb_if #(
    parameter int NREQ = 4,
    parameter int W    = 16,
    parameter int IDW  = 2
);
    logic [NREQ-1:0]   req_valid;
    logic [NREQ*W-1:0] req_a;
    logic [NREQ*W-1:0] req_b;
    logic [NREQ-1:0]   req_ready;
    logic              res_valid;
    logic              res_ready;
    logic [IDW-1:0]    res_id;
    logic [2*W-1:0]    res_p;
    logic              busy;

    // Client side: issues requests and consumes results.
    modport master (
        output req_valid, req_a, req_b, res_ready,
        input  req_ready, res_valid, res_id, res_p, busy
    );

    // Arbiter side.
    modport slave (
        input  req_valid, req_a, req_b, res_ready,
        output req_ready, res_valid, res_id, res_p, busy
    );
endinterface

// File: rtl/mult_core.sv
// Purely combinational unsigned W x W multiplier producing the full 2*W
// product. Kept as its own module so a gate-level multiplier can replace it.
module mult_core #(
    parameter int W = 16
) (
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic [2*W-1:0] p
);
    // Widen both operands first so no product bits are lost.
    assign p = (2*W)'(a) * (2*W)'(b);
endmodule

// File: rtl/mult_share_arb.sv
// Round-robin sharing of one multiplier between NREQ requesters. One
// operation is in flight at a time: IDLE grants, CALC waits LAT cycles for
// the multiplier to settle, DONE holds the tagged result until accepted.
module mult_share_arb
    import mult_share_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int W    = DEF_W,
    parameter int LAT  = DEF_LAT,
    parameter int IDW  = 2
) (
    input  logic             clk,
    input  logic             reset,
    mult_share_arb_if.slave  bus,
    output state_t           dbg_state,
    output logic [IDW-1:0]   dbg_rr_ptr
);
    localparam int CW = (LAT > 1) ? clog2(LAT) : 1;

    // The result tag must be wide enough to name every requester.
    if (IDW < clog2(NREQ)) begin : g_idw_chk
        $error("mult_share_arb: IDW too narrow for NREQ");
    end

    state_t            state, state_nx;
    logic [IDW-1:0]    rr_ptr;
    logic [IDW-1:0]    id_r;
    logic [CW-1:0]     cnt;
    logic [W-1:0]      a_r, b_r;
    logic [2*W-1:0]    prod;
    logic              res_valid_r;
    logic [IDW-1:0]    res_id_r;
    logic [2*W-1:0]    res_p_r;

    logic [2*NREQ-1:0] valid_x2;
    logic [NREQ-1:0]   valid_rot;
    logic              found;
    logic [IDW-1:0]    g;
    logic [IDW-1:0]    g_next;
    logic [NREQ-1:0]   grant_vec;
    logic [NREQ-1:0]   grant;
    logic [W-1:0]      a_sel, b_sel;
    int                pos;

    // Rotate requests so bit 0 is the requester at rr_ptr.
    assign valid_x2  = {bus.req_valid, bus.req_valid};
    assign valid_rot = NREQ'(valid_x2 >> rr_ptr);

    // Round-robin pick: first valid requester at or after rr_ptr.
    always_comb begin
        found = 1'b0;
        g     = '0;
        pos   = 0;
        for (int k = 0; k < NREQ; k++) begin
            if (!found && valid_rot[k]) begin
                found = 1'b1;
                pos   = int'(rr_ptr) + k;
                if (pos >= NREQ) pos = pos - NREQ;
                g     = IDW'(pos);
            end
        end
    end

    // Next pointer wraps after the last requester; with NREQ=1 it stays 0.
    assign g_next = (g == IDW'(NREQ - 1)) ? '0 : g + IDW'(1);

    // One-hot grant and operand mux for the picked requester.
    always_comb begin
        grant_vec = '0;
        a_sel     = '0;
        b_sel     = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (found && g == IDW'(i)) begin
                grant_vec[i] = 1'b1;
                a_sel        = bus.req_a[i*W +: W];
                b_sel        = bus.req_b[i*W +: W];
            end
        end
    end

    // Multiplier works on the captured operands for the whole CALC phase.
    mult_core #(.W(W)) u_core (
        .a (a_r),
        .b (b_r),
        .p (prod)
    );

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    // Next-state and grant decode.
    always_comb begin
        state_nx = state;
        grant    = '0;
        unique case (state)
            IDLE: begin
                if (found) begin
                    grant    = grant_vec;
                    state_nx = CALC;
                end
            end
            CALC: begin
                if (cnt == '0) state_nx = DONE;
            end
            DONE: begin
                if (bus.res_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Operand capture, settle counter, pointer and result registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr      <= '0;
            id_r        <= '0;
            cnt         <= '0;
            a_r         <= '0;
            b_r         <= '0;
            res_valid_r <= 1'b0;
            res_id_r    <= '0;
            res_p_r     <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (found) begin
                        a_r    <= a_sel;
                        b_r    <= b_sel;
                        id_r   <= g;
                        rr_ptr <= g_next;
                        cnt    <= CW'(LAT - 1);
                    end
                end
                CALC: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CW'(1);
                    end else begin
                        res_p_r     <= prod;
                        res_id_r    <= id_r;
                        res_valid_r <= 1'b1;
                    end
                end
                DONE: begin
                    if (bus.res_ready) res_valid_r <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign bus.req_ready = reset ? '0 : grant;
    assign bus.res_valid = res_valid_r;
    assign bus.res_id    = res_id_r;
    assign bus.res_p     = res_p_r;
    assign bus.busy      = (state != IDLE);
    assign dbg_state     = state;
    assign dbg_rr_ptr    = rr_ptr;

endmodule

// File: tb/tb_mult_share_arb.sv
// Bench for mult_share_arb: directed scenarios with literal expectations,
// then randomized traffic, all checked every cycle against a transaction
// level model of the arbiter.
module tb_mult_share_arb;
    import mult_share_pkg::*;

    localparam int NREQ = 4;
    localparam int W    = 16;
    localparam int LAT  = 2;
    localparam int IDW  = 2;
    localparam int EW   = IDW + 2*W;

    logic clk;
    logic reset;
    state_t dbg_state;
    logic [IDW-1:0] dbg_rr_ptr;

    mult_share_arb_if #(.NREQ(NREQ), .W(W), .IDW(IDW)) bus ();

    mult_share_arb #(.NREQ(NREQ), .W(W), .LAT(LAT), .IDW(IDW)) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus),
        .dbg_state  (dbg_state),
        .dbg_rr_ptr (dbg_rr_ptr)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- bookkeeping ----------------
    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int done_cnt = 0;
    logic [NREQ-1:0] hold_mask = '0;

    int              acc_id_q[$];
    int              acc_cyc_q[$];
    logic [NREQ-1:0] acc_rdy_q[$];
    int              rise_cyc_q[$];
    logic [IDW-1:0]  done_id_q[$];
    logic [2*W-1:0]  done_p_q[$];
    logic [EW-1:0]   exp_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- transaction-level model ----------------
    // One job in flight; result visible from LAT+1 cycles after the accept
    // cycle until the cycle it is taken; the last result persists.
    int             m_rr;
    bit             m_busy;
    int             m_acc;
    logic [IDW-1:0] m_id, m_last_id;
    logic [2*W-1:0] m_p, m_last_p;
    int             m_g;
    bit             m_vld;
    bit             prev_v;
    logic [NREQ-1:0] m_rdy;
    logic [2*W-1:0] m_a, m_b;
    logic [EW-1:0]  sb_e;
    state_t         m_st;
    int             m_j;

    initial begin : compare
        m_rr = 0; m_busy = 0; m_acc = 0; m_id = '0; m_p = '0;
        m_last_id = '0; m_last_p = '0; prev_v = 0;
        forever begin
            @(negedge clk);
            if (reset) begin
                check("rst_req_ready", bus.req_ready, 0);
                check("rst_res_valid", bus.res_valid, 0);
                check("rst_busy", bus.busy, 0);
                check("rst_res_p", bus.res_p, 0);
                check("rst_res_id", bus.res_id, 0);
                check("rst_rr_ptr", dbg_rr_ptr, 0);
                m_rr = 0; m_busy = 0; m_last_id = '0; m_last_p = '0;
                prev_v = 0;
                exp_q.delete();
            end else begin
                m_g = -1;
                if (!m_busy) begin
                    for (int k = 0; k < NREQ; k++) begin
                        m_j = (m_rr + k) % NREQ;
                        if (m_g < 0 && bus.req_valid[m_j]) m_g = m_j;
                    end
                end
                m_rdy = '0;
                if (m_g >= 0) m_rdy[m_g] = 1'b1;
                m_vld = m_busy && (cyc - m_acc >= LAT + 1);
                m_st  = !m_busy ? IDLE : (m_vld ? DONE : CALC);

                check("req_ready", bus.req_ready, m_rdy);
                check("res_valid", bus.res_valid, m_vld);
                check("busy", bus.busy, m_busy);
                check("res_p", bus.res_p, m_vld ? m_p : m_last_p);
                check("res_id", bus.res_id, m_vld ? m_id : m_last_id);
                check("rr_ptr", dbg_rr_ptr, m_rr);
                check("state", 64'(dbg_state), 64'(m_st));

                // logs of what the DUT did
                for (int i = 0; i < NREQ; i++) begin
                    if (bus.req_ready[i] && bus.req_valid[i]) begin
                        acc_id_q.push_back(i);
                        acc_cyc_q.push_back(cyc);
                        acc_rdy_q.push_back(bus.req_ready);
                    end
                end
                if (bus.res_valid && !prev_v) rise_cyc_q.push_back(cyc);
                prev_v = bus.res_valid;
                if (bus.res_valid && bus.res_ready) begin
                    done_cnt++;
                    done_id_q.push_back(bus.res_id);
                    done_p_q.push_back(bus.res_p);
                    if (exp_q.size() == 0) begin
                        check("sb_unexpected_result", 1, 0);
                    end else begin
                        sb_e = exp_q.pop_front();
                        check("sb_result", {bus.res_id, bus.res_p}, sb_e);
                    end
                end

                // advance model across the coming edge
                if (m_g >= 0) begin
                    m_a    = (2*W)'(bus.req_a[m_g*W +: W]);
                    m_b    = (2*W)'(bus.req_b[m_g*W +: W]);
                    m_busy = 1;
                    m_acc  = cyc;
                    m_id   = IDW'(m_g);
                    m_p    = m_a * m_b;
                    m_rr   = (m_g + 1) % NREQ;
                    exp_q.push_back({m_id, m_p});
                end else if (m_vld && bus.res_ready) begin
                    m_busy    = 0;
                    m_last_id = m_id;
                    m_last_p  = m_p;
                end
            end
            cyc++;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic issue(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
        bus.req_a[i*W +: W] = a;
        bus.req_b[i*W +: W] = b;
        bus.req_valid[i]    = 1'b1;
    endtask

    task automatic wait_done(input int target);
        int budget;
        budget = 0;
        while (done_cnt < target && budget < 300) begin
            step();
            budget++;
        end
        check("done_count", done_cnt, target);
    endtask

    // Requesters drop valid after their accept edge unless held.
    initial begin : requester_release
        logic [NREQ-1:0] acc;
        forever begin
            @(negedge clk);
            acc = reset ? '0 : (bus.req_valid & bus.req_ready);
            @(posedge clk);
            #1;
            for (int i = 0; i < NREQ; i++)
                if (acc[i] && !hold_mask[i]) bus.req_valid[i] = 1'b0;
        end
    end

    logic [31:0] fair_p [5] = '{32'h0000AAAA, 32'h00015554, 32'h0001FFFE, 32'h0002AAA8, 32'h0000AAAA};

    // ---------------- stimulus ----------------
    initial begin : stimulus
        int base_acc, base_done, base_rise, budget;
        reset         = 1'b1;
        bus.req_valid = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.res_ready = 1'b1;
        repeat (3) step();
        reset = 1'b0;
        step();

        // single request
        issue(0, 16'h5555, 16'hFFFF);
        wait_done(1);
        check("t1_grant_vec", acc_rdy_q[$], 4'b0001);
        check("t1_latency", rise_cyc_q[$] - acc_cyc_q[$], LAT + 1);
        check("t1_res_p", done_p_q[$], 32'h5554AAAB);
        check("t1_res_id", done_id_q[$], 0);

        // full-scale operands
        issue(2, 16'hFFFF, 16'hFFFF);
        wait_done(2);
        check("t2_res_p", done_p_q[$], 32'hFFFE0001);
        check("t2_res_id", done_id_q[$], 2);
        issue(3, 16'hFFFF, 16'h0000);
        wait_done(3);
        check("t2b_res_p", done_p_q[$], 32'h00000000);
        check("t2b_res_id", done_id_q[$], 3);

        // fairness with all requesters held valid
        base_acc  = acc_id_q.size();
        base_done = done_cnt;
        hold_mask = '1;
        for (int i = 0; i < NREQ; i++) issue(i, 16'hAAAA, W'(i + 1));
        budget = 0;
        while (acc_id_q.size() < base_acc + 5 && budget < 100) begin
            step();
            budget++;
        end
        hold_mask     = '0;
        bus.req_valid = '0;
        wait_done(base_done + 5);
        for (int k = 0; k < 5; k++) begin
            check("fair_grant", acc_id_q[base_acc + k], k % NREQ);
            check("fair_res_p", done_p_q[base_done + k], fair_p[k]);
            if (k > 0) check("fair_spacing", acc_cyc_q[base_acc + k] - acc_cyc_q[base_acc + k - 1], LAT + 2);
        end

        // backpressure
        bus.res_ready = 1'b0;
        base_done = done_cnt;
        issue(1, 16'h0100, 16'h0300);
        budget = 0;
        while (!bus.res_valid && budget < 50) begin
            step();
            budget++;
        end
        issue(2, 16'h0002, 16'h0003);
        for (int k = 0; k < 10; k++) begin
            step();
            check("bp_res_valid", bus.res_valid, 1);
            check("bp_busy", bus.busy, 1);
            check("bp_req_ready", bus.req_ready, 0);
            check("bp_res_p", bus.res_p, 32'h00030000);
            check("bp_res_id", bus.res_id, 1);
        end
        bus.res_ready = 1'b1;
        step();
        check("bp_release_valid", bus.res_valid, 0);
        check("bp_release_busy", bus.busy, 0);
        wait_done(base_done + 2);
        check("bp_second_p", done_p_q[$], 32'h00000006);
        check("bp_second_id", done_id_q[$], 2);

        // reset in the middle of CALC
        base_done = done_cnt;
        base_rise = rise_cyc_q.size();
        issue(0, 16'h0007, 16'h0009);
        budget = 0;
        while (!bus.busy && budget < 20) begin
            step();
            budget++;
        end
        check("rm_in_calc", 64'(dbg_state), 64'(CALC));
        #1;
        reset         = 1'b1;
        bus.req_valid = '0;
        #1;
        check("rm_async_valid", bus.res_valid, 0);
        check("rm_async_busy", bus.busy, 0);
        check("rm_async_rr", dbg_rr_ptr, 0);
        check("rm_async_ready", bus.req_ready, 0);
        step();
        step();
        reset = 1'b0;
        repeat (4) step();
        check("rm_no_pulse", rise_cyc_q.size(), base_rise);
        check("rm_no_done", done_cnt, base_done);
        issue(1, 16'hAAAA, 16'hFFFF);
        wait_done(base_done + 1);
        check("rm_res_p", done_p_q[$], 32'hAAA95556);
        check("rm_res_id", done_id_q[$], 1);

        // idle with stray res_ready
        for (int k = 0; k < 8; k++) begin
            bus.res_ready = 1'($urandom_range(0, 1));
            step();
            check("idle_req_ready", bus.req_ready, 0);
            check("idle_res_valid", bus.res_valid, 0);
            check("idle_state", 64'(dbg_state), 64'(IDLE));
        end

        // randomized traffic
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < NREQ; i++)
                if (!bus.req_valid[i] && $urandom_range(0, 3) == 0)
                    issue(i, W'($urandom), W'($urandom));
            bus.res_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        bus.res_ready = 1'b1;
        budget = 0;
        while ((bus.req_valid != '0 || bus.busy) && budget < 400) begin
            step();
            budget++;
        end
        step();
        check("drain_idle", {bus.req_valid, bus.busy}, 0);
        check("drain_sb_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mult_share_arb.md
Name: mult_share_arb

Overview:
- Shares one W x W unsigned multiplier between NREQ requesters.
- Round-robin arbitration, a valid/ready handshake on each request port, and a multi-cycle compute phase of fixed length LAT, which models the combinational multiplier's settling budget.
- A single tagged result channel that holds its value until it is accepted.
- Sits between client blocks and the multiplier datapath; one operation is in flight at a time.

Parameters:
- NREQ, 4, number of requesters (2..8).
- W, 16, operand width; product width is 2*W.
- LAT, 2, compute cycles between operand capture and result register load (>=1).
- IDW, 2, result tag width; must be >= clog2(NREQ).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- req_valid  input  NREQ  per-requester request; must stay high until accepted.
- req_a  input  NREQ*W  operand A; slice i belongs to requester i.
- req_b  input  NREQ*W  operand B; slice i belongs to requester i.
- req_ready  output  NREQ  one-hot accept strobe, combinational in IDLE.
- res_valid  output  1  result available.
- res_ready  input  1  consumer accepts the result.
- res_id  output  IDW  index of the requester that owns res_p.
- res_p  output  2*W  product A*B.
- busy  output  1  high in CALC or DONE.

Behaviour:
- Reset (async, active-high) sets: state=IDLE, rr_ptr=0, cnt=0, a_r=b_r=0, res_valid=0, res_id=0, res_p=0. Under reset req_ready=0 and busy=0. Reset during CALC or DONE abandons the operation; no res_valid pulse follows.
- States: IDLE, CALC, DONE.
- IDLE:
  - g = first i with req_valid[i]=1, scanning rr_ptr, rr_ptr+1, ... mod NREQ.
  - If a g exists: req_ready = one-hot(g) in the same cycle. At the clock edge, capture a_r/b_r from slice g, set id_r=g, rr_ptr=(g+1) mod NREQ, cnt=LAT-1, state=CALC.
  - If no request is valid: req_ready=0 and rr_ptr is unchanged.
- CALC:
  - req_ready=0; the product of a_r and b_r is computed by the sub-module.
  - At each edge with cnt!=0: cnt decrements.
  - At the edge with cnt==0: res_p=a_r*b_r (full 2*W bits, unsigned, no truncation), res_id=id_r, res_valid=1, state=DONE.
- DONE:
  - res_valid, res_p and res_id are held stable. req_ready=0.
  - At an edge with res_ready=1: res_valid=0, state=IDLE. res_p and res_id keep their last values.
- Latency: res_valid is high from LAT edges after the accept edge. Minimum cycle per operation is LAT+2 clocks when res_ready is tied high.
- Fairness: with all requesters permanently valid, grants rotate 0,1,2,...,NREQ-1,0,...
- req_valid dropping before accept is a protocol violation. The block only grants on the current-cycle value, so a dropped request is simply not granted.
- req_ready is never asserted outside IDLE or during reset. At most one bit of req_ready is set.
- res_ready arriving while res_valid=0 is ignored.
- IDLE never accepts a request in the same cycle that DONE completes; DONE always returns to IDLE first.
- NREQ=1: rr_ptr is always 0.

Decomposition:
- Package mult_share_pkg holds:
  - the state encoding constants (IDLE=0, CALC=1, DONE=2);
  - the clog2 function used to check IDW;
  - the default W/LAT constants.
- Sub-module mult_core (input W a, input W b, output 2*W p): purely combinational unsigned product. It is instantiated once on a_r/b_r so a gate-level multiplier can be swapped in later.
- Arbiter priority logic stays inline.

Test Plan:
- Single request: requester 0 issues a=0x5555, b=0xFFFF with LAT=2. Required: req_ready=0001 in that cycle, res_valid high 2 edges later, res_p=0x5554AAAB, res_id=0.
- Full-scale operands: requester 2 issues a=0xFFFF, b=0xFFFF, then requester 3 issues a=0xFFFF, b=0x0000. Required: res_p=0xFFFE0001 with res_id=2, then res_p=0x00000000 with res_id=3.
- All four requesters held valid, res_ready=1, a_i=0xAAAA, b_i=i+1. Required: grant order 0,1,2,3,0. res_p values 0x0000AAAA, 0x00015554, 0x0001FFFE, 0x0002AAA8. Successive accepts are spaced exactly LAT+2 cycles apart.
- Backpressure: res_ready held low for 10 cycles after res_valid. Required: res_p, res_id and res_valid stay stable, req_ready=0 and busy=1 throughout. Completion happens on the first edge where res_ready=1.
- Reset mid-operation: assert reset during CALC. Required: res_valid=0, busy=0 and rr_ptr=0 immediately (async). After release, requester 1 alone issues a=0xAAAA, b=0xFFFF and gets res_p=0xAAA95556.
- Idle/no-request check: no requests plus spurious res_ready pulses. Required: req_ready=0, res_valid=0, and state stays IDLE.
